pd_frame_ctrl: RTL

//  Frame-level sequencer for the serial "11010" pattern detector (PD_fsm).

---
 rtl/pd_frame_ctrl_pkg.sv | 25 ++
 rtl/PD_fsm.sv | 38 +++
 rtl/pd_frame_serializer.sv | 46 ++++
 rtl/pd_frame_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pd_frame_ctrl_pkg.sv
// Shared types for the "11010" frame sequencer: controller states, detector states
// and the detector output lag that the first-match position has to compensate for.
package pd_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pd_state_e;

  // Detector states, named by the longest prefix of 11010 matched so far.
  typedef enum logic [2:0] {
    DS_NONE  = 3'd0,
    DS_1     = 3'd1,
    DS_11    = 3'd2,
    DS_110   = 3'd3,
    DS_1101  = 3'd4,
    DS_FOUND = 3'd5
  } pd_det_state_e;

  // Cycles between a bit entering the detector and its pattern_found reflecting it.
  localparam int PD_DET_LAT = 1;

endpackage

// File: rtl/PD_fsm.sv
// Overlapping serial "11010" detector, Moore output; pattern_found is high for the cycle after the last bit.
// Latency 1 cycle; no backpressure, consumes one bit per clock; rst is synchronous active-high.
module PD_fsm
  import pd_frame_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic stream_in,
  output logic pattern_found
);

  pd_det_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DS_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = DS_NONE;
    unique case (state_q)
      DS_NONE:  state_d = stream_in ? DS_1    : DS_NONE;
      DS_1:     state_d = stream_in ? DS_11   : DS_NONE;
      DS_11:    state_d = stream_in ? DS_11   : DS_110;
      DS_110:   state_d = stream_in ? DS_1101 : DS_NONE;
      // "11011" still ends in "11", so a failed match keeps two ones of progress.
      DS_1101:  state_d = stream_in ? DS_11   : DS_FOUND;
      DS_FOUND: state_d = stream_in ? DS_1    : DS_NONE;
      default:  state_d = DS_NONE;
    endcase
  end

  assign pattern_found = (state_q == DS_FOUND);

endmodule

// File: rtl/pd_frame_serializer.sv
// Parallel-load shift register that presents a frame MSB-first, with the index of the bit on msb.
// Load/shift take effect on the next edge; no backpressure, the controller decides when to shift.
module pd_frame_serializer #(
  parameter int  FRAME_W = 16,
  localparam int IDX_W   = $clog2(FRAME_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_dat,
  input  logic               shift_en,
  output logic               msb,
  output logic [IDX_W-1:0]   bit_idx,
  output logic               last_bit
);

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    if (load) begin
      shreg_d   = load_dat;
      bit_idx_d = '0;
    end else if (shift_en) begin
      shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
      bit_idx_d = bit_idx_q + IDX_W'(1);
    end
  end

  assign msb      = shreg_q[FRAME_W-1];
  assign bit_idx  = bit_idx_q;
  assign last_bit = (bit_idx_q == IDX_W'(FRAME_W - 1));

endmodule

// File: rtl/pd_frame_ctrl.sv
// Streams each accepted frame MSB-first into the 11010 detector and reports match count and first position.
// Result valid FRAME_W+1 edges after accept; result held in DONE until out_ready, no new frame taken meanwhile.
module pd_frame_ctrl
  import pd_frame_ctrl_pkg::*;
#(
  parameter int  FRAME_W = 16,
  parameter int  CNT_W   = 4,
  localparam int IDX_W   = $clog2(FRAME_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  output logic               det_rst,
  output logic               det_bit,
  input  logic               det_found,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat,
  output logic [IDX_W-1:0]   out_first_pos
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(FRAME_W - 1);

  pd_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [IDX_W-1:0] first_pos_q, first_pos_d;
  logic             found_seen_q, found_seen_d;

  logic             ser_load;
  logic             ser_shift;
  logic             ser_msb;
  logic [IDX_W-1:0] ser_bit_idx;
  logic             ser_last;
  logic             acct_en;
  logic [IDX_W-1:0] acct_pos;

  pd_frame_serializer #(
    .FRAME_W (FRAME_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .load_dat (in_frame),
    .shift_en (ser_shift),
    .msb      (ser_msb),
    .bit_idx  (ser_bit_idx),
    .last_bit (ser_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      sat_q        <= 1'b0;
      first_pos_q  <= '0;
      found_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      first_pos_q  <= first_pos_d;
      found_seen_q <= found_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sat_d        = sat_q;
    first_pos_d  = first_pos_q;
    found_seen_d = found_seen_q;
    in_ready     = 1'b0;
    det_rst      = 1'b0;
    det_bit      = 1'b0;
    out_valid    = 1'b0;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    acct_en      = 1'b0;
    acct_pos     = '0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        det_rst  = 1'b1;
        if (in_valid) begin
          ser_load     = 1'b1;
          count_d      = '0;
          sat_d        = 1'b0;
          first_pos_d  = '0;
          found_seen_d = 1'b0;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_bit   = ser_msb;
        ser_shift = 1'b1;
        acct_en   = 1'b1;
        // det_found now reflects the bit presented PD_DET_LAT cycles earlier.
        acct_pos  = ser_bit_idx - IDX_W'(PD_DET_LAT);
        if (ser_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        acct_en  = 1'b1;
        acct_pos = LAST_POS;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        det_rst   = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (acct_en && det_found) begin
      if (count_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
      if (!found_seen_q) begin
        found_seen_d = 1'b1;
        first_pos_d  = acct_pos;
      end
    end
  end

  assign out_count     = count_q;
  assign out_sat       = sat_q;
  assign out_first_pos = first_pos_q;

endmodule
